// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline stall/clear generation with EX/WB shadows, debug state
//            and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_defines_pkg;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [3:0] {
    OP_NO_OP    = 4'd0,
    OP_COMP     = 4'd1,
    OP_COMP_IMM = 4'd2,
    OP_LOAD     = 4'd3,
    OP_STORE    = 4'd4,
    OP_BRANCH   = 4'd5,
    OP_JAL      = 4'd6,
    OP_JALR     = 4'd7,
    OP_LUI      = 4'd8,
    OP_AUIPC    = 4'd9,
    OP_SYSTEM   = 4'd10
  } decoded_opcode;
endpackage

module hazard_ctrl
  import riscv_defines_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int ADDR_WIDTH = riscv_defines_pkg::REG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  decoded_opcode         instr_type_i,
  input  logic [ADDR_WIDTH-1:0] read_addr1_i,
  input  logic [ADDR_WIDTH-1:0] read_addr2_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic                  write_en_i,
  input  logic                  redirect_i,
  input  logic                  ex_busy_i,
  input  logic                  mem_ready_i,
  output logic                  pc_stall_o,
  output logic                  if_to_id_stall_o,
  output logic                  id_to_ex_stall_o,
  output logic                  ex_to_wb_stall_o,
  output logic                  if_to_id_clear_o,
  output logic                  id_to_ex_clear_o,
  output logic                  ex_to_wb_clear_o,
  output logic [1:0]            state_o,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o,
  output logic [CNT_WIDTH-1:0]  flush_count_o
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    EX_WAIT     = 2'd2,
    MEM_WAIT    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  state_t                r_state;
  state_t                w_state_next;
  decoded_opcode         r_ex_type;
  logic [ADDR_WIDTH-1:0] r_ex_waddr;
  logic                  r_ex_we;
  decoded_opcode         r_wb_type;
  logic [ADDR_WIDTH-1:0] r_wb_waddr;
  logic                  r_wb_we;

  logic w_use_rs1, w_use_rs2;
  logic w_memw, w_busy, w_rdr, w_lu;

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (instr_type_i)
      OP_COMP, OP_STORE, OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OP_COMP_IMM, OP_LOAD, OP_JALR: w_use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign w_memw = ((r_wb_type == OP_LOAD) || (r_wb_type == OP_STORE)) && !mem_ready_i;
  assign w_busy = ex_busy_i;
  assign w_rdr  = redirect_i;
  assign w_lu   = (r_ex_type == OP_LOAD) && r_ex_we && (r_ex_waddr != '0) &&
                  ((w_use_rs1 && (read_addr1_i == r_ex_waddr)) ||
                   (w_use_rs2 && (read_addr2_i == r_ex_waddr)));

  // Highest-priority condition alone decides the controls and the next state.
  always_comb begin
    pc_stall_o       = 1'b0;
    if_to_id_stall_o = 1'b0;
    id_to_ex_stall_o = 1'b0;
    ex_to_wb_stall_o = 1'b0;
    if_to_id_clear_o = 1'b0;
    id_to_ex_clear_o = 1'b0;
    ex_to_wb_clear_o = 1'b0;
    w_state_next     = RUN;
    if (w_memw) begin
      pc_stall_o       = 1'b1;
      if_to_id_stall_o = 1'b1;
      id_to_ex_stall_o = 1'b1;
      ex_to_wb_stall_o = 1'b1;
      w_state_next     = MEM_WAIT;
    end else if (w_busy) begin
      pc_stall_o       = 1'b1;
      if_to_id_stall_o = 1'b1;
      id_to_ex_stall_o = 1'b1;
      ex_to_wb_clear_o = 1'b1;
      w_state_next     = EX_WAIT;
    end else if (w_rdr) begin
      if_to_id_clear_o = 1'b1;
      id_to_ex_clear_o = 1'b1;
    end else if (w_lu) begin
      pc_stall_o       = 1'b1;
      if_to_id_stall_o = 1'b1;
      id_to_ex_clear_o = 1'b1;
      w_state_next     = LOAD_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign state_o = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_type  <= OP_NO_OP;
      r_ex_waddr <= '0;
      r_ex_we    <= 1'b0;
      r_wb_type  <= OP_NO_OP;
      r_wb_waddr <= '0;
      r_wb_we    <= 1'b0;
    end else begin
      if (id_to_ex_clear_o) begin
        r_ex_type <= OP_NO_OP;
        r_ex_we   <= 1'b0;
      end else if (!id_to_ex_stall_o) begin
        r_ex_type  <= instr_type_i;
        r_ex_waddr <= write_addr_i;
        r_ex_we    <= write_en_i;
      end
      if (ex_to_wb_clear_o) begin
        r_wb_type <= OP_NO_OP;
        r_wb_we   <= 1'b0;
      end else if (!ex_to_wb_stall_o) begin
        r_wb_type  <= r_ex_type;
        r_wb_waddr <= r_ex_waddr;
        r_wb_we    <= r_ex_we;
      end
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (pc_stall_o && (stall_cycles_o != c_cnt_max))
        stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
      if (if_to_id_clear_o && (flush_count_o != c_cnt_max))
        flush_count_o <= flush_count_o + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
  import riscv_defines_pkg::*;

  localparam int CNT_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  decoded_opcode        instr_type = OP_NO_OP;
  logic [4:0]           rs1 = '0, rs2 = '0, rd = '0;
  logic                 we = 1'b0, redirect = 1'b0, busy = 1'b0, mem_ready = 1'b1;
  logic                 pc_stall, ifs, ids, exs, ifc, idc, exc;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.CNT_WIDTH(CNT_WIDTH), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_type_i(instr_type), .read_addr1_i(rs1), .read_addr2_i(rs2),
    .write_addr_i(rd), .write_en_i(we),
    .redirect_i(redirect), .ex_busy_i(busy), .mem_ready_i(mem_ready),
    .pc_stall_o(pc_stall), .if_to_id_stall_o(ifs), .id_to_ex_stall_o(ids),
    .ex_to_wb_stall_o(exs), .if_to_id_clear_o(ifc), .id_to_ex_clear_o(idc),
    .ex_to_wb_clear_o(exc), .state_o(state),
    .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
  );

  always #5 clk = ~clk;

  // {pc_stall, if_stall, id_stall, ex_stall, if_clear, id_clear, ex_clear}
  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_LU   = 7'b1100010;
  localparam logic [6:0] E_BUSY = 7'b1110001;
  localparam logic [6:0] E_RDR  = 7'b0000110;
  localparam logic [6:0] E_MEMW = 7'b1111000;

  typedef struct {
    string         name;
    decoded_opcode prev_type;
    logic [4:0]    prev_rd;
    logic          prev_we;
    decoded_opcode cur_type;
    logic [4:0]    cur_rs1;
    logic [4:0]    cur_rs2;
    logic          rdr;
    logic          bsy;
    logic [6:0]    exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [6:0] exp);
    check(name, {25'd0, pc_stall, ifs, ids, exs, ifc, idc, exc}, {25'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_type = OP_NO_OP; rs1 = '0; rs2 = '0; rd = '0; we = 1'b0;
    redirect = 1'b0; busy = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // Push a load through to WB so the next cycles see a WB memory access.
  task automatic load_to_wb();
    instr_type = OP_LOAD; rd = 5'd9; we = 1'b1; rs1 = 5'd1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    vecs[0]  = '{"lu_comp_rs2",    OP_LOAD, 5'd5, 1'b1, OP_COMP,     5'd1, 5'd5, 1'b0, 1'b0, E_LU};
    vecs[1]  = '{"lu_rd0",         OP_LOAD, 5'd0, 1'b1, OP_COMP,     5'd0, 5'd0, 1'b0, 1'b0, E_NONE};
    vecs[2]  = '{"imm_rs2_unused", OP_LOAD, 5'd7, 1'b1, OP_COMP_IMM, 5'd1, 5'd7, 1'b0, 1'b0, E_NONE};
    vecs[3]  = '{"lu_imm_rs1",     OP_LOAD, 5'd7, 1'b1, OP_COMP_IMM, 5'd7, 5'd0, 1'b0, 1'b0, E_LU};
    vecs[4]  = '{"lu_no_we",       OP_LOAD, 5'd5, 1'b0, OP_COMP,     5'd5, 5'd0, 1'b0, 1'b0, E_NONE};
    vecs[5]  = '{"ex_not_load",    OP_COMP, 5'd5, 1'b1, OP_COMP,     5'd5, 5'd0, 1'b0, 1'b0, E_NONE};
    vecs[6]  = '{"rdr_over_lu",    OP_LOAD, 5'd5, 1'b1, OP_COMP,     5'd5, 5'd0, 1'b1, 1'b0, E_RDR};
    vecs[7]  = '{"lu_store_rs2",   OP_LOAD, 5'd5, 1'b1, OP_STORE,    5'd2, 5'd5, 1'b0, 1'b0, E_LU};
    vecs[8]  = '{"jal_no_use",     OP_LOAD, 5'd5, 1'b1, OP_JAL,      5'd5, 5'd5, 1'b0, 1'b0, E_NONE};
    vecs[9]  = '{"busy_over_lu",   OP_LOAD, 5'd5, 1'b1, OP_BRANCH,   5'd1, 5'd5, 1'b0, 1'b1, E_BUSY};
    vecs[10] = '{"busy_over_rdr",  OP_NO_OP,5'd0, 1'b0, OP_NO_OP,    5'd0, 5'd0, 1'b1, 1'b1, E_BUSY};
    vecs[11] = '{"rdr_only",       OP_NO_OP,5'd0, 1'b0, OP_NO_OP,    5'd0, 5'd0, 1'b1, 1'b0, E_RDR};
    vecs[12] = '{"lu_jalr",        OP_LOAD, 5'd3, 1'b1, OP_JALR,     5'd3, 5'd0, 1'b0, 1'b0, E_LU};

    // Reset state
    idle_inputs();
    #2;
    check_outs("reset_outs", E_NONE);
    check("reset_state", 32'(state), 32'd0);
    check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    check("reset_flush_cnt", 32'(flush_count), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      do_reset();
      instr_type = vecs[i].prev_type; rd = vecs[i].prev_rd; we = vecs[i].prev_we;
      tick();
      idle_inputs();
      instr_type = vecs[i].cur_type; rs1 = vecs[i].cur_rs1; rs2 = vecs[i].cur_rs2;
      rd = 5'd6; we = 1'b1;
      redirect = vecs[i].rdr; busy = vecs[i].bsy;
      #1;
      check_outs(vecs[i].name, vecs[i].exp);
    end

    // Load-use: single bubble cycle then clean
    do_reset();
    instr_type = OP_LOAD; rd = 5'd5; we = 1'b1;
    tick();
    instr_type = OP_COMP; rs1 = 5'd0; rs2 = 5'd5; rd = 5'd6;
    #1;
    check_outs("lu_seq_stall", E_LU);
    tick();
    check_outs("lu_seq_after", E_NONE);
    check("lu_seq_state", 32'(state), 32'd1);
    check("lu_seq_stall_cnt", 32'(stall_cycles), 32'd1);
    tick();
    check("lu_seq_state_run", 32'(state), 32'd0);

    // Redirect with load-use present
    do_reset();
    instr_type = OP_LOAD; rd = 5'd5; we = 1'b1;
    tick();
    instr_type = OP_COMP; rs1 = 5'd5; rd = 5'd6; redirect = 1'b1;
    #1;
    check_outs("rdr_lu_outs", E_RDR);
    tick();
    redirect = 1'b0;
    #1;
    check("rdr_lu_flush", 32'(flush_count), 32'd1);
    check("rdr_lu_state", 32'(state), 32'd0);
    check("rdr_lu_stall_cnt", 32'(stall_cycles), 32'd0);

    // Memory wait for three cycles
    do_reset();
    load_to_wb();
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_outs($sformatf("memw_outs_%0d", c), E_MEMW);
      tick();
      check("memw_state", 32'(state), 32'd3);
    end
    check("memw_stall_cnt", 32'(stall_cycles), 32'd3);
    mem_ready = 1'b1;
    #1;
    check_outs("memw_release", E_NONE);
    tick();
    check("memw_state_run", 32'(state), 32'd0);
    check("memw_stall_cnt_hold", 32'(stall_cycles), 32'd3);

    // EX busy masking a pending redirect
    do_reset();
    busy = 1'b1; redirect = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_outs($sformatf("busy_outs_%0d", c), E_BUSY);
      tick();
      check("busy_state", 32'(state), 32'd2);
      check("busy_no_flush", 32'(flush_count), 32'd0);
    end
    busy = 1'b0;
    #1;
    check_outs("busy_rdr_applied", E_RDR);
    tick();
    check("busy_flush_cnt", 32'(flush_count), 32'd1);
    check("busy_stall_cnt", 32'(stall_cycles), 32'd4);
    check("busy_state_run", 32'(state), 32'd0);

    // Counter saturation
    do_reset();
    busy = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    check("stall_cnt_sat", 32'(stall_cycles), 32'd7);
    busy = 1'b0; redirect = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    check("flush_cnt_sat", 32'(flush_count), 32'd7);
    check("stall_cnt_sat_hold", 32'(stall_cycles), 32'd7);

    // Async reset during MEM_WAIT
    do_reset();
    load_to_wb();
    mem_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_state", 32'(state), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check_outs("async_rst_outs", E_NONE);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_stall_cnt", 32'(stall_cycles), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    check_outs("post_rst_no_stall", E_NONE);
    check("post_rst_state", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
